// File: rtl/input_event_conditioner.sv
// rtl/input_event_conditioner.sv - synchronise, debounce, edge-detect and arbitrate slow input levels
//
// Purpose: each of N raw asynchronous levels passes through a SYNC_STAGES-deep
// synchroniser and a debouncer. Accepted level changes matching EDGE_MODE
// (0 rising, 1 falling, 2 both) on unmasked channels latch a pending bit.
// Pending events are handed out one at a time, highest index first, through a
// registered valid/ready output stage.
//
// Ports:
//   clk           clock, rising edge
//   rst_n         asynchronous active-low reset
//   data_in[N]    raw asynchronous levels
//   mask[N]       1 = channel may raise events
//   evt_ready     consumer accepts the held event
//   clr_overflow  clears all overflow bits (a same-cycle new overflow wins)
//   evt_valid     an event is held on evt_onehot/evt_index
//   evt_onehot[N] one-hot channel of the held event
//   evt_index     binary channel index of the held event
//   pending[N]    events latched but not yet presented
//   overflow[N]   sticky: an event was lost on that channel
module input_event_conditioner #(
    parameter int N           = 4,
    parameter int SYNC_STAGES = 3,
    parameter int DB_COUNT    = 2,
    parameter int DB_W        = 8,
    parameter int EDGE_MODE   = 0,
    localparam int IDX_W      = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     data_in,
    input  logic [N-1:0]     mask,
    input  logic             evt_ready,
    input  logic             clr_overflow,
    output logic             evt_valid,
    output logic [N-1:0]     evt_onehot,
    output logic [IDX_W-1:0] evt_index,
    output logic [N-1:0]     pending,
    output logic [N-1:0]     overflow
);

    logic [N-1:0]     sync_q [SYNC_STAGES];
    logic [N-1:0]     synced;
    logic [N-1:0]     stable_q, stable_d;
    logic [DB_W-1:0]  cnt_q [N];
    logic [DB_W-1:0]  cnt_d [N];
    logic [N-1:0]     db_edge;
    logic [N-1:0]     rise_edge, fall_edge, qual;
    logic [N-1:0]     pending_q, pending_d;
    logic [N-1:0]     overflow_q, overflow_d;
    logic             evt_valid_q, evt_valid_d;
    logic [N-1:0]     evt_onehot_q, evt_onehot_d;
    logic [IDX_W-1:0] evt_index_q, evt_index_d;
    logic             grant_found;
    logic [IDX_W-1:0] grant_idx;
    logic             load;
    logic [N-1:0]     consume;

    assign synced = sync_q[SYNC_STAGES-1];

    // A change is accepted only after the synced level has differed from the
    // stable level for DB_COUNT consecutive cycles; any return resets the count.
    always_comb begin
        stable_d = stable_q;
        db_edge  = '0;
        for (int i = 0; i < N; i++) begin
            cnt_d[i] = '0;
            if (synced[i] != stable_q[i]) begin
                if (cnt_q[i] == DB_W'(DB_COUNT - 1)) begin
                    stable_d[i] = synced[i];
                    db_edge[i]  = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign rise_edge = db_edge & synced;
    assign fall_edge = db_edge & ~synced;
    assign qual = mask & ((EDGE_MODE == 0) ? rise_edge :
                          (EDGE_MODE == 1) ? fall_edge : db_edge);

    // Highest set pending bit wins: later loop iterations override earlier ones.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < N; i++) begin
            if (pending_q[i]) begin
                grant_found = 1'b1;
                grant_idx   = IDX_W'(i);
            end
        end
    end

    assign load    = !evt_valid_q || evt_ready;
    assign consume = (load && grant_found) ? (N'(1) << grant_idx) : '0;

    // A new edge is OR-ed in after the consume clear, so set wins over clear;
    // overflow only when the bit stays pending through this cycle.
    always_comb begin
        pending_d    = (pending_q & ~consume) | qual;
        overflow_d   = (clr_overflow ? '0 : overflow_q) | (qual & pending_q & ~consume);
        evt_valid_d  = evt_valid_q;
        evt_onehot_d = evt_onehot_q;
        evt_index_d  = evt_index_q;
        if (load) begin
            evt_valid_d  = grant_found;
            evt_onehot_d = consume;
            evt_index_d  = grant_found ? grant_idx : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
            stable_q     <= '0;
            pending_q    <= '0;
            overflow_q   <= '0;
            evt_valid_q  <= 1'b0;
            evt_onehot_q <= '0;
            evt_index_q  <= '0;
        end else begin
            sync_q[0] <= data_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            stable_q     <= stable_d;
            pending_q    <= pending_d;
            overflow_q   <= overflow_d;
            evt_valid_q  <= evt_valid_d;
            evt_onehot_q <= evt_onehot_d;
            evt_index_q  <= evt_index_d;
        end
    end

    assign evt_valid  = evt_valid_q;
    assign evt_onehot = evt_onehot_q;
    assign evt_index  = evt_index_q;
    assign pending    = pending_q;
    assign overflow   = overflow_q;

endmodule
